// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for I-cache read, D-cache read and D-cache write-back lines.
// Define MEM_ARB_STARVE_GUARD_EN to add the I-side starvation guard (otherwise fixed DW > DR > IC).
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int LINE_W     = 128,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_read_req,
   input  logic [ADDR_W-1:0] ic_read_addr,
   output logic              ic_read_ack,
   output logic [LINE_W-1:0] ic_read_data,
   input  logic              dc_read_req,
   input  logic [ADDR_W-1:0] dc_read_addr,
   output logic              dc_read_ack,
   output logic [LINE_W-1:0] dc_read_data,
   input  logic              dc_write_req,
   input  logic [ADDR_W-1:0] dc_write_addr,
   input  logic [LINE_W-1:0] dc_write_data,
   output logic              dc_write_ack,
   output logic              mem_enable,
   output logic              mem_rw,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_data_in,
   input  logic [LINE_W-1:0] mem_data_out,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_RESP = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_IC = 2'd0, OWN_DR = 2'd1, OWN_DW = 2'd2} owner_t;

   generate
      if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
         $error("mem_arbiter: STARVE_MAX must be in 1..15");
      end
   endgenerate

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic                mem_enable_q, mem_enable_d;
   logic                mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_data_in_q, mem_data_in_d;
   logic [LINE_W-1:0]   ic_data_q, ic_data_d;
   logic [LINE_W-1:0]   dc_data_q, dc_data_d;
   logic                ic_ack_q, ic_ack_d;
   logic                dr_ack_q, dr_ack_d;
   logic                dw_ack_q, dw_ack_d;

   logic                any_req;
   logic                ic_promote;
   owner_t              grant;

   assign any_req = ic_read_req | dc_read_req | dc_write_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_q, starve_d;

   assign ic_promote = ic_read_req && (starve_q == STARVE_LIM);

   // Counts only data-side grants that bypassed a waiting I-cache request.
   always_comb begin
      starve_d = starve_q;
      if (state_q == S_IDLE && any_req) begin
         if (grant == OWN_IC || !ic_read_req) begin
            starve_d = 4'd0;
         end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign ic_promote = 1'b0;
`endif

   always_comb begin
      if (ic_promote) begin
         grant = OWN_IC;
      end else if (dc_write_req) begin
         grant = OWN_DW;
      end else if (dc_read_req) begin
         grant = OWN_DR;
      end else begin
         grant = OWN_IC;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      mem_enable_d  = mem_enable_q;
      mem_rw_d      = mem_rw_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      ic_data_d     = ic_data_q;
      dc_data_d     = dc_data_q;
      ic_ack_d      = 1'b0;
      dr_ack_d      = 1'b0;
      dw_ack_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d      = S_MEM;
               owner_d      = grant;
               mem_enable_d = 1'b1;
               case (grant)
                  OWN_DW: begin
                     mem_addr_d    = dc_write_addr;
                     mem_rw_d      = 1'b1;
                     mem_data_in_d = dc_write_data;
                  end
                  OWN_DR: begin
                     mem_addr_d = dc_read_addr;
                     mem_rw_d   = 1'b0;
                  end
                  default: begin
                     mem_addr_d = ic_read_addr;
                     mem_rw_d   = 1'b0;
                  end
               endcase
            end
         end

         S_MEM: begin
            // Address, direction and write data stay frozen until memory answers.
            if (mem_ack) begin
               state_d      = S_RESP;
               mem_enable_d = 1'b0;
               case (owner_q)
                  OWN_IC: begin
                     ic_data_d = mem_data_out;
                     ic_ack_d  = 1'b1;
                  end
                  OWN_DR: begin
                     dc_data_d = mem_data_out;
                     dr_ack_d  = 1'b1;
                  end
                  OWN_DW: begin
                     dw_ack_d = 1'b1;
                  end
                  default: begin
                     state_d = S_RESP;
                  end
               endcase
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         owner_q       <= OWN_IC;
         mem_enable_q  <= 1'b0;
         mem_rw_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         ic_data_q     <= '0;
         dc_data_q     <= '0;
         ic_ack_q      <= 1'b0;
         dr_ack_q      <= 1'b0;
         dw_ack_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         mem_enable_q  <= mem_enable_d;
         mem_rw_q      <= mem_rw_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         ic_data_q     <= ic_data_d;
         dc_data_q     <= dc_data_d;
         ic_ack_q      <= ic_ack_d;
         dr_ack_q      <= dr_ack_d;
         dw_ack_q      <= dw_ack_d;
      end
   end

   assign ic_read_ack  = ic_ack_q;
   assign dc_read_ack  = dr_ack_q;
   assign dc_write_ack = dw_ack_q;
   assign ic_read_data = ic_data_q;
   assign dc_read_data = dc_data_q;
   assign mem_enable   = mem_enable_q;
   assign mem_rw       = mem_rw_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data_in  = mem_data_in_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, priority order, starvation guard (or its absence),
// asynchronous reset mid-transfer and a spurious memory ack.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int LW = 128;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD  = 1'b1;
   localparam int N_XFER = 6;
`else
   localparam bit GUARD  = 1'b0;
   localparam int N_XFER = 20;
`endif

   localparam logic [LW-1:0] L_IC1 = 128'h0123_4567_89AB_CDEF_1111_2222_3333_4444;
   localparam logic [LW-1:0] L_DW  = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_5555_AAAA;
   localparam logic [LW-1:0] L_DR  = 128'h2222_2222_3333_3333_4444_4444_5555_5555;
   localparam logic [LW-1:0] L_IC2 = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
   localparam logic [LW-1:0] L_IC3 = 128'hA1A1_B2B2_C3C3_D4D4_E5E5_F6F6_0707_1818;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_read_req, dc_read_req, dc_write_req;
   logic [AW-1:0] ic_read_addr, dc_read_addr, dc_write_addr;
   logic [LW-1:0] dc_write_data;
   logic          ic_read_ack, dc_read_ack, dc_write_ack;
   logic [LW-1:0] ic_read_data, dc_read_data;
   logic          mem_enable, mem_rw, mem_ack, busy;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_data_in, mem_data_out;

   int checks = 0;
   int errors = 0;
   int ic_acks = 0;
   int dr_acks = 0;
   int dw_acks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
      .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
      .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
      .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
      .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
      .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
      .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .busy(busy)
   );

   always @(negedge clk) begin
      if (ic_read_ack)  ic_acks++;
      if (dc_read_ack)  dr_acks++;
      if (dc_write_ack) dw_acks++;
   end

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic          is_ic;
      logic [LW-1:0] line_k;

      reset = 1'b0;
      ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0;
      ic_read_addr = '0; dc_read_addr = '0; dc_write_addr = '0;
      dc_write_data = '0; mem_ack = 1'b0; mem_data_out = '0;
      tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_mem_enable", mem_enable, 1'b0);
      check("rst_mem_rw", mem_rw, 1'b0);
      check("rst_mem_addr", mem_addr, '0);
      check("rst_acks", {ic_read_ack, dc_read_ack, dc_write_ack}, 3'b000);
      check("rst_ic_data", ic_read_data, '0);
      reset = 1'b1;
      tick();

      // Single IC read, memory answers in the second MEM cycle.
      ic_read_req = 1'b1; ic_read_addr = 32'h40;
      tick();
      check("ic1_mem_enable", mem_enable, 1'b1);
      check("ic1_mem_rw", mem_rw, 1'b0);
      check("ic1_mem_addr", mem_addr, 32'h40);
      check("ic1_busy", busy, 1'b1);
      tick();
      check("ic1_hold_enable", mem_enable, 1'b1);
      check("ic1_hold_addr", mem_addr, 32'h40);
      check("ic1_no_early_ack", ic_read_ack, 1'b0);
      mem_ack = 1'b1; mem_data_out = L_IC1;
      tick();
      check("ic1_ack", ic_read_ack, 1'b1);
      check("ic1_data", ic_read_data, L_IC1);
      check("ic1_enable_low", mem_enable, 1'b0);
      check("ic1_resp_busy", busy, 1'b1);
      $display("txn ic_read addr=40 data=%0h", ic_read_data);
      mem_ack = 1'b0; ic_read_req = 1'b0;
      tick();
      check("ic1_ack_pulse", ic_read_ack, 1'b0);
      check("ic1_idle", busy, 1'b0);

      // All three requesters at once: DW, then DR, then IC.
      dc_write_req = 1'b1; dc_write_addr = 32'h100; dc_write_data = L_DW;
      dc_read_req  = 1'b1; dc_read_addr  = 32'h200;
      ic_read_req  = 1'b1; ic_read_addr  = 32'h300;
      tick();
      check("pri_dw_addr", mem_addr, 32'h100);
      check("pri_dw_rw", mem_rw, 1'b1);
      check("pri_dw_wdata", mem_data_in, L_DW);
      mem_ack = 1'b1;
      tick();
      check("pri_dw_ack", {ic_read_ack, dc_read_ack, dc_write_ack}, 3'b001);
      $display("txn dc_write addr=100");
      mem_ack = 1'b0; dc_write_req = 1'b0;
      tick();
      check("pri_dw_pulse", dc_write_ack, 1'b0);
      tick();
      check("pri_dr_addr", mem_addr, 32'h200);
      check("pri_dr_rw", mem_rw, 1'b0);
      mem_ack = 1'b1; mem_data_out = L_DR;
      tick();
      check("pri_dr_ack", {ic_read_ack, dc_read_ack, dc_write_ack}, 3'b010);
      check("pri_dr_data", dc_read_data, L_DR);
      $display("txn dc_read addr=200 data=%0h", dc_read_data);
      mem_ack = 1'b0; dc_read_req = 1'b0;
      tick();
      check("pri_dr_pulse", dc_read_ack, 1'b0);
      tick();
      check("pri_ic_addr", mem_addr, 32'h300);
      mem_ack = 1'b1; mem_data_out = L_IC2;
      tick();
      check("pri_ic_ack", {ic_read_ack, dc_read_ack, dc_write_ack}, 3'b100);
      check("pri_ic_data", ic_read_data, L_IC2);
      check("pri_dr_data_hold", dc_read_data, L_DR);
      $display("txn ic_read addr=300 data=%0h", ic_read_data);
      mem_ack = 1'b0; ic_read_req = 1'b0;
      tick();
      check("pri_ic_pulse", ic_read_ack, 1'b0);

      // DR and IC held, memory acks at once; the guard lets IC in after four DR grants.
      dc_read_req = 1'b1; ic_read_req = 1'b1;
      for (int k = 0; k < N_XFER; k++) begin
         is_ic  = GUARD && (k == 4);
         line_k = {4{32'hA5A5_0000 + 32'(k)}};
         tick();
         check("stv_enable", mem_enable, 1'b1);
         check("stv_addr", mem_addr, is_ic ? 32'h300 : 32'h200);
         mem_ack = 1'b1; mem_data_out = line_k;
         tick();
         if (is_ic) begin
            check("stv_ic_ack", ic_read_ack, 1'b1);
            check("stv_ic_data", ic_read_data, line_k);
            ic_read_req = 1'b0;
         end else begin
            check("stv_dr_ack", dc_read_ack, 1'b1);
            check("stv_dr_data", dc_read_data, line_k);
         end
         $display("txn starve_loop k=%0d addr=%0h", k, mem_addr);
         mem_ack = 1'b0;
         tick();
      end
      dc_read_req = 1'b0; ic_read_req = 1'b0;
      tick();
      check("stv_idle", busy, 1'b0);
      check("stv_ic_ack_count", 32'(ic_acks), GUARD ? 32'd3 : 32'd2);

      // Asynchronous reset while a DR transfer sits in MEM.
      dc_read_req = 1'b1; dc_read_addr = 32'h240;
      tick();
      check("arst_pre_enable", mem_enable, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("arst_enable", mem_enable, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_mem_addr", mem_addr, '0);
      check("arst_mem_rw", mem_rw, 1'b0);
      check("arst_data", {ic_read_data, dc_read_data} == '0, 1'b1);
      check("arst_acks", {ic_read_ack, dc_read_ack, dc_write_ack}, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("arst_rearb_enable", mem_enable, 1'b1);
      check("arst_rearb_addr", mem_addr, 32'h240);
      mem_ack = 1'b1; mem_data_out = L_DR;
      tick();
      check("arst_rearb_ack", dc_read_ack, 1'b1);
      $display("txn dc_read addr=240 after reset");
      mem_ack = 1'b0; dc_read_req = 1'b0;
      tick();

      // Spurious memory ack while idle changes nothing.
      mem_ack = 1'b1; mem_data_out = L_IC1;
      tick();
      check("spur_busy", busy, 1'b0);
      check("spur_enable", mem_enable, 1'b0);
      check("spur_acks", {ic_read_ack, dc_read_ack, dc_write_ack}, 3'b000);
      check("spur_ic_data", ic_read_data, '0);
      check("spur_mem_addr", mem_addr, 32'h240);
      mem_ack = 1'b0;
      tick();
      check("spur_still_idle", busy, 1'b0);
      ic_read_req = 1'b1; ic_read_addr = 32'h80;
      tick();
      check("post_ic_addr", mem_addr, 32'h80);
      mem_ack = 1'b1; mem_data_out = L_IC3;
      tick();
      check("post_ic_ack", ic_read_ack, 1'b1);
      check("post_ic_data", ic_read_data, L_IC3);
      $display("txn ic_read addr=80 data=%0h", ic_read_data);
      mem_ack = 1'b0; ic_read_req = 1'b0;
      tick();
      tick();

      check("total_ic_acks", 32'(ic_acks), GUARD ? 32'd4 : 32'd3);
      check("total_dr_acks", 32'(dr_acks), GUARD ? 32'd7 : 32'd22);
      check("total_dw_acks", 32'(dw_acks), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port main-memory arbiter between the instruction cache read-miss port and the data cache read-miss and write-back ports. It sits between both `cache` instances and the external memory interface of `cpu`. It serializes line transfers with a registered FSM, fixed priority, and an optional starvation guard for the instruction side. It forwards read lines back to the owning cache.

## Interface
- `ADDR_W`, default 32: address width (`REG_SIZE`).
- `LINE_W`, default 128: line data width (`WIDTH`).
- `STARVE_MAX`, default 4: consecutive data-side grants allowed while `ic_read_req` waits. Used only with the guard enabled. Legal range 1..15.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ic_read_req` in 1: I-cache line read request.
- `ic_read_addr` in ADDR_W: I-cache line address.
- `ic_read_ack` out 1: one-cycle completion pulse for the I-cache read.
- `ic_read_data` out LINE_W: line returned to the I-cache.
- `dc_read_req` in 1: D-cache line read request.
- `dc_read_addr` in ADDR_W: D-cache read address.
- `dc_read_ack` out 1: one-cycle completion pulse for the D-cache read.
- `dc_read_data` out LINE_W: line returned to the D-cache.
- `dc_write_req` in 1: D-cache write-back request.
- `dc_write_addr` in ADDR_W: write-back address.
- `dc_write_data` in LINE_W: write-back line.
- `dc_write_ack` out 1: one-cycle completion pulse for the write-back.
- `mem_enable` out 1: memory transaction active.
- `mem_rw` out 1: 1 = write, 0 = read.
- `mem_ack` in 1: memory completion, single-cycle pulse.
- `mem_addr` out ADDR_W: memory address.
- `mem_data_in` out LINE_W: write data sent to memory.
- `mem_data_out` in LINE_W: read data from memory, valid in the `mem_ack` cycle.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, MEM, RESP. A 2-bit `owner` register holds one of IC, DR, DW.
- In IDLE, arbitration picks the highest-priority pending request: DW > DR > IC. With the guard enabled, the guard may override this order (see Configuration).
- On a grant, the FSM goes to MEM. It registers `mem_addr` from the owner's address, `mem_rw` = 1 only for DW, and `mem_data_in` from `dc_write_data` for DW (otherwise unchanged). `mem_enable` is set to 1.
- In MEM, all memory outputs are held stable until `mem_ack`.
- On `mem_ack`, the FSM goes to RESP and clears `mem_enable`. For a read, it latches `mem_data_out` into the owner's `*_read_data`.
- In RESP, the owner's ack is 1 for exactly this cycle, then the FSM returns to IDLE.
- The ack decode is registered, so all acks are glitch-free flop outputs.
- Requester rules:
  - Hold req, address and data stable from assertion until its ack.
  - Deassert req in the cycle after the ack.
  - Req sampled high in the IDLE cycle right after RESP is treated as a new request.
- A req dropped before its ack is illegal. The arbiter still completes the memory transaction and pulses the ack.
- A req asserted while the FSM is not in IDLE waits. No request is lost or reordered.
- `*_read_data` holds its last value until the next read completion for that port.
- `mem_ack` outside MEM is ignored.
- Reset, asserted at any time including mid-transaction:
  - FSM goes to IDLE and `owner` to IC.
  - All acks, `mem_enable`, `mem_rw` and `busy` go to 0.
  - `mem_addr`, `mem_data_in`, `ic_read_data` and `dc_read_data` go to 0.
  - The starvation counter goes to 0.
  - The in-flight memory transaction is abandoned; memory must tolerate `mem_enable` dropping.

## Timing
- A req first seen in IDLE in cycle N gives `mem_enable`=1 in cycle N+1.
- `mem_ack` in cycle M gives the requester ack and valid data in cycle M+1, with `mem_enable`=0 in cycle M+1.
- With memory acking in the first MEM cycle, one transfer takes 3 cycles: grant, MEM, RESP. Back-to-back transfers to different requesters are therefore 3 cycles apart.
- No combinational path from any req or `mem_ack` to any output.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: a 4-bit counter counts DR/DW grants made while `ic_read_req` is high.
  - The counter clears on any IC grant.
  - The counter also clears on any grant made while `ic_read_req` is low.
  - When the counter equals `STARVE_MAX` and `ic_read_req` is high, IC is granted ahead of DW and DR.
- Macro not defined: pure fixed priority DW > DR > IC. The counter logic is absent, and IC may starve indefinitely.

## Test plan
- Single IC read, `ic_read_addr`=0x40, memory acks 2 cycles after `mem_enable`:
  - `mem_enable` rises 1 cycle after req, with `mem_rw`=0 and `mem_addr`=0x40.
  - `ic_read_ack` pulses once with `ic_read_data` equal to the memory line.
  - The whole transfer spans 4 cycles.
- DW, DR and IC all asserted in the same cycle: grants go in order DW, DR, IC.
  - The DW transfer shows `mem_rw`=1 and `mem_data_in`=`dc_write_data`.
  - Each ack is a single pulse.
- With the guard enabled and `STARVE_MAX`=4: DR held continuously, IC held, memory acks immediately. Exactly 4 DR transfers complete, then IC is granted, then DR resumes.
- With the guard disabled, same stimulus for 20 transfers: IC is never granted and `ic_read_ack` stays 0.
- Reset asserted in MEM with `mem_enable`=1: all outputs are 0 asynchronously, and `busy` is 0.
  - After release, a pending DR is re-arbitrated from IDLE.
- Spurious `mem_ack` in IDLE: no ack output and no state change.
  - A subsequent IC read completes normally.
